mmio_hub: RTL and testbench

Parametrised memory-mapped I/O interconnect between the soft CPU data port and N peripheral slaves (DMEM, timer, VGA, seg, Ethernet regs, ...). It generalises flat write-select/read-select decoding with a per-slave base/mask table, a registered request/acknowledge handshake so slow slaves can stall the CPU, and a bus-timeout watchdog. It also provides hub-owned error CSRs for software diagnostics.

---
 rtl/mmio_hub_pkg.sv | 27 ++
 rtl/mmio_decode.sv | 40 ++++
 rtl/mmio_hub.sv | 207 ++++++++++++++++++++
 tb/tb_mmio_hub.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_hub_pkg.sv
// ============================================================================
//  mmio_hub_pkg : shared types and constants for the MMIO interconnect hub
//  Revision     : 1.0
// ============================================================================
`default_nettype none

package mmio_hub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [3:0] CSR_OFF_ERR_COUNT = 4'h0;
  localparam logic [3:0] CSR_OFF_LAST_ERR  = 4'h4;
  localparam logic [3:0] CSR_OFF_STATUS    = 4'h8;

  localparam logic [1:0] ERR_KIND_DECODE  = 2'b01;
  localparam logic [1:0] ERR_KIND_TIMEOUT = 2'b10;

  localparam logic [31:0] DEF_CSR_BASE = 32'h1000_F000;
  localparam logic [31:0] CSR_WIN_MASK = 32'hFFFF_FFF0;

endpackage

`default_nettype wire

// File: rtl/mmio_decode.sv
// ============================================================================
//  mmio_decode : combinational base/mask priority decoder (CSR window first,
//                then lowest-index matching slave)
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module mmio_decode
  import mmio_hub_pkg::*;
#(
  parameter int                           N_SLAVES = 8,
  parameter int                           ADDR_W   = 32,
  parameter int                           IDX_W    = 3,
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_MASK = {N_SLAVES{32'hFFFF_F000}},
  parameter logic [ADDR_W-1:0]            CSR_BASE = ADDR_W'(DEF_CSR_BASE)
) (
  input  logic [ADDR_W-1:0] addr_i,
  output logic              hit_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              csr_hit_o
);

  assign csr_hit_o = ((addr_i & ADDR_W'(CSR_WIN_MASK)) == CSR_BASE);

  // Scan downwards so the lowest matching index is the one left standing.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
        hit_o = 1'b1;
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/mmio_hub.sv
// ============================================================================
//  mmio_hub : single-outstanding MMIO interconnect with req/ack handshake,
//             bus-timeout watchdog and hub-owned error CSRs
//  Revision : 1.0
// ============================================================================
`default_nettype none

module mmio_hub
  import mmio_hub_pkg::*;
#(
  parameter int                           N_SLAVES = 8,
  parameter int                           ADDR_W   = 32,
  parameter int                           DATA_W   = 32,
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_BASE = '0,
  parameter logic [N_SLAVES*ADDR_W-1:0]   SLV_MASK = {N_SLAVES{32'hFFFF_F000}},
  parameter logic [ADDR_W-1:0]            CSR_BASE = ADDR_W'(DEF_CSR_BASE),
  parameter int                           TIMEOUT  = 255
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         cpu_req_i,
  input  logic                         cpu_we_i,
  input  logic [ADDR_W-1:0]            cpu_addr_i,
  input  logic [DATA_W-1:0]            cpu_wdata_i,
  output logic [DATA_W-1:0]            cpu_rdata_o,
  output logic                         cpu_ready_o,
  output logic                         cpu_err_o,
  output logic [N_SLAVES-1:0]          slv_sel_o,
  output logic                         slv_we_o,
  output logic [ADDR_W-1:0]            slv_addr_o,
  output logic [DATA_W-1:0]            slv_wdata_o,
  input  logic [N_SLAVES*DATA_W-1:0]   slv_rdata_i,
  input  logic [N_SLAVES-1:0]          slv_ack_i
);

  localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CNT_W = 16;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [N_SLAVES-1:0]   sel_q, sel_d;
  logic                  we_q, we_d;
  logic [ADDR_W-1:0]     saddr_q, saddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic [DATA_W-1:0]     err_cnt_q, err_cnt_d;
  logic [ADDR_W-1:0]     err_addr_q, err_addr_d;
  logic [1:0]            status_q, status_d;

  logic                  dec_hit, dec_csr;
  logic [IDX_W-1:0]      dec_idx;
  logic                  log_en;
  logic [ADDR_W-1:0]     log_addr;
  logic [1:0]            log_kind;
  logic                  sel_ack;
  logic [DATA_W-1:0]     sel_rdata;

  mmio_decode #(
    .N_SLAVES (N_SLAVES),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .CSR_BASE (CSR_BASE)
  ) u_decode (
    .addr_i    (cpu_addr_i),
    .hit_o     (dec_hit),
    .idx_o     (dec_idx),
    .csr_hit_o (dec_csr)
  );

  assign sel_ack   = slv_ack_i[idx_q];
  assign sel_rdata = slv_rdata_i[idx_q*DATA_W +: DATA_W];

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    sel_d      = sel_q;
    we_d       = we_q;
    saddr_d    = saddr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    status_d   = status_q;
    log_en     = 1'b0;
    log_addr   = cpu_addr_i;
    log_kind   = ERR_KIND_DECODE;

    case (state_q)
      IDLE: begin
        if (cpu_req_i) begin
          if (dec_csr) begin
            state_d = RESP;
            err_d   = 1'b0;
            rdata_d = '0;
            if (cpu_we_i) begin
              if (cpu_addr_i[3:0] == CSR_OFF_ERR_COUNT) err_cnt_d = '0;
            end else begin
              case (cpu_addr_i[3:0])
                CSR_OFF_ERR_COUNT: rdata_d = err_cnt_q;
                CSR_OFF_LAST_ERR:  rdata_d = DATA_W'(err_addr_q);
                CSR_OFF_STATUS:    rdata_d = DATA_W'(status_q);
                default:           rdata_d = '0;
              endcase
            end
          end else if (dec_hit) begin
            state_d        = WAIT;
            idx_d          = dec_idx;
            addr_d         = cpu_addr_i;
            we_d           = cpu_we_i;
            wdata_d        = cpu_wdata_i;
            saddr_d        = cpu_addr_i - SLV_BASE[dec_idx*ADDR_W +: ADDR_W];
            cnt_d          = '0;
            sel_d          = '0;
            sel_d[dec_idx] = 1'b1;
          end else begin
            state_d  = RESP;
            err_d    = 1'b1;
            rdata_d  = '0;
            log_en   = 1'b1;
            log_addr = cpu_addr_i;
            log_kind = ERR_KIND_DECODE;
          end
        end
      end
      WAIT: begin
        // An ack arriving on the expiry cycle still completes cleanly.
        if (sel_ack) begin
          state_d = RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? '0 : sel_rdata;
          sel_d   = '0;
          we_d    = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT)) begin
          state_d  = RESP;
          err_d    = 1'b1;
          rdata_d  = '0;
          sel_d    = '0;
          we_d     = 1'b0;
          log_en   = 1'b1;
          log_addr = addr_q;
          log_kind = ERR_KIND_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (log_en) begin
      if (err_cnt_q != '1) err_cnt_d = err_cnt_q + DATA_W'(1);
      err_addr_d = log_addr;
      status_d   = log_kind;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      sel_q      <= '0;
      we_q       <= 1'b0;
      saddr_q    <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      saddr_q    <= saddr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      status_q   <= status_d;
    end
  end

  assign cpu_ready_o = (state_q == RESP);
  assign cpu_rdata_o = rdata_q;
  assign cpu_err_o   = err_q;
  assign slv_sel_o   = sel_q;
  assign slv_we_o    = we_q;
  assign slv_addr_o  = saddr_q;
  assign slv_wdata_o = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mmio_hub.sv
// ============================================================================
//  tb_mmio_hub : directed bench with a transaction-level reference model
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_hub;

  localparam int NS  = 8;
  localparam int TMO = 4;
  localparam logic [31:0] CSRB = 32'h1000_F000;
  localparam logic [NS*32-1:0] P_BASE = {
    32'h1006_0000, 32'h1005_0000, 32'h1004_0000, 32'h1003_0000,
    32'h1002_1000, 32'h1001_0000, 32'h1002_0000, 32'h1000_0000};
  localparam logic [NS*32-1:0] P_MASK = {
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_F000,
    32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_F000};

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0]       cpu_addr = '0, cpu_wdata = '0;
  logic [31:0]       cpu_rdata;
  logic              cpu_ready, cpu_err;
  logic [NS-1:0]     slv_sel;
  logic              slv_we;
  logic [31:0]       slv_addr, slv_wdata;
  logic [NS*32-1:0]  slv_rdata;
  logic [NS-1:0]     slv_ack;

  mmio_hub #(
    .N_SLAVES (NS), .ADDR_W (32), .DATA_W (32),
    .SLV_BASE (P_BASE), .SLV_MASK (P_MASK), .CSR_BASE (CSRB), .TIMEOUT (TMO)
  ) dut (
    .clk_i (clk), .rst_ni (rst_n),
    .cpu_req_i (cpu_req), .cpu_we_i (cpu_we), .cpu_addr_i (cpu_addr),
    .cpu_wdata_i (cpu_wdata), .cpu_rdata_o (cpu_rdata), .cpu_ready_o (cpu_ready),
    .cpu_err_o (cpu_err), .slv_sel_o (slv_sel), .slv_we_o (slv_we),
    .slv_addr_o (slv_addr), .slv_wdata_o (slv_wdata),
    .slv_rdata_i (slv_rdata), .slv_ack_i (slv_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave behaviour: the selected slave acks ack_k cycles after select (-1 = never)
  int          ack_k = 0;
  logic        stray_ack = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] ack_data [NS];
  initial for (int i = 0; i < NS; i++) ack_data[i] = 32'hD000_0000 | i;
  always @(posedge clk) wait_cnt <= (|slv_sel) ? wait_cnt + 1 : 0;
  always_comb begin
    slv_ack = '0;
    for (int i = 0; i < NS; i++)
      slv_ack[i] = slv_sel[i] && (ack_k >= 0) && (wait_cnt == ack_k);
    if (stray_ack) slv_ack[5] = 1'b1;
    for (int i = 0; i < NS; i++) slv_rdata[i*32 +: 32] = ack_data[i];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: architectural CSRs plus the expectation of the access in flight
  logic [31:0] m_cnt = 0, m_last = 0;
  logic [1:0]  m_status = 0;
  logic        m_active = 0, m_err = 0, m_we = 0;
  int          m_req_cyc = 0, m_rdy_cyc = 0, m_idx = -1;
  logic [31:0] m_rdata = 0, m_saddr = 0, m_wdata = 0;

  task automatic m_log(input logic [31:0] a, input logic [1:0] kind);
    if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
    m_last   = a;
    m_status = kind;
  endtask

  task automatic model_access(input logic we, input logic [31:0] a, input logic [31:0] wd, input int k);
    int lat;
    m_idx = -1; m_err = 0; m_rdata = 0; m_we = we; m_wdata = wd; m_saddr = 0;
    if ((a & 32'hFFFF_FFF0) == CSRB) begin
      lat = 1;
      if (!we) begin
        case (a[3:0])
          4'h0: m_rdata = m_cnt;
          4'h4: m_rdata = m_last;
          4'h8: m_rdata = {30'd0, m_status};
          default: m_rdata = 0;
        endcase
      end else if (a[3:0] == 4'h0) m_cnt = 0;
    end else begin
      for (int i = 0; i < NS; i++)
        if (m_idx < 0 && ((a & P_MASK[i*32 +: 32]) == P_BASE[i*32 +: 32])) m_idx = i;
      if (m_idx < 0) begin
        lat = 1; m_err = 1; m_log(a, 2'b01);
      end else begin
        m_saddr = a - P_BASE[m_idx*32 +: 32];
        if (k >= 0 && k <= TMO) begin
          lat = 2 + k;
          m_rdata = we ? 32'd0 : ack_data[m_idx];
        end else begin
          lat = TMO + 2; m_err = 1; m_log(a, 2'b10);
        end
      end
    end
    m_req_cyc = cyc;
    m_rdy_cyc = cyc + lat;
    m_active  = 1;
  endtask

  // Per-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin : cmp
    logic [NS-1:0] esel;
    logic          erdy;
    erdy = m_active && (cyc == m_rdy_cyc);
    esel = '0;
    if (m_active && m_idx >= 0 && cyc > m_req_cyc && cyc < m_rdy_cyc) esel[m_idx] = 1'b1;
    chk("cyc_ready", cpu_ready, erdy);
    chk("cyc_sel", slv_sel, esel);
    if (erdy) begin
      chk("cyc_err", cpu_err, m_err);
      chk("cyc_rdata", cpu_rdata, m_rdata);
    end
    if (esel != 0) begin
      chk("cyc_we", slv_we, m_we);
      chk("cyc_saddr", slv_addr, m_saddr);
      chk("cyc_wdata", slv_wdata, m_wdata);
    end
  end

  task automatic access(input logic we, input logic [31:0] a, input logic [31:0] wd,
                        input int k, input logic stray,
                        output logic [31:0] rd, output logic er, output int lat,
                        output logic [31:0] s_addr, output logic [NS-1:0] s_sel);
    @(posedge clk); #1;
    ack_k = k; stray_ack = stray;
    model_access(we, a, wd, k);
    cpu_we = we; cpu_addr = a; cpu_wdata = wd; cpu_req = 1'b1;
    lat = -1; rd = 0; er = 0; s_addr = 0; s_sel = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (n == 1) begin s_addr = slv_addr; s_sel = slv_sel; end
      if (cpu_ready) begin lat = n; rd = cpu_rdata; er = cpu_err; break; end
    end
    cpu_req = 1'b0; stray_ack = 1'b0;
    if (lat < 0) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout: no cpu_ready within 40 cycles for addr %h", a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got hang expected finish");
    $fatal(1, "watchdog");
  end

  logic [31:0]   rd, sa;
  logic          er;
  int            lat;
  logic [NS-1:0] ss;

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", cpu_ready, 0); chk("rst_err", cpu_err, 0);
    chk("rst_rdata", cpu_rdata, 0); chk("rst_sel", slv_sel, 0);
    chk("rst_we", slv_we, 0); chk("rst_saddr", slv_addr, 0); chk("rst_wdata", slv_wdata, 0);
    rst_n = 1'b1;

    ack_data[2] = 32'h1234_5678;
    access(0, 32'h1001_0024, 0, 0, 0, rd, er, lat, sa, ss);
    chk("rd2_lat", lat, 2); chk("rd2_data", rd, 32'h1234_5678);
    chk("rd2_err", er, 0); chk("rd2_saddr", sa, 32'h24); chk("rd2_sel", ss, 8'h04);

    access(1, 32'h2000_0000, 32'hDEAD_BEEF, 0, 0, rd, er, lat, sa, ss);
    chk("miss_lat", lat, 1); chk("miss_err", er, 1);
    access(0, 32'h1000_F000, 0, 0, 0, rd, er, lat, sa, ss);
    chk("csr_cnt1", rd, 1); chk("csr_lat", lat, 1); chk("csr_err", er, 0);
    access(0, 32'h1000_F004, 0, 0, 0, rd, er, lat, sa, ss);
    chk("csr_last1", rd, 32'h2000_0000);
    access(0, 32'h1000_F008, 0, 0, 0, rd, er, lat, sa, ss);
    chk("csr_stat1", rd, 32'h1);

    access(0, 32'h1003_0010, 0, -1, 0, rd, er, lat, sa, ss);
    chk("tmo_lat", lat, 6); chk("tmo_err", er, 1); chk("tmo_rdata", rd, 0);
    chk("tmo_sel_after", slv_sel, 0);
    access(0, 32'h1000_F008, 0, 0, 0, rd, er, lat, sa, ss);
    chk("csr_stat2", rd, 32'h2);
    access(0, 32'h1000_F000, 0, 0, 0, rd, er, lat, sa, ss);
    chk("csr_cnt2", rd, 2);

    ack_data[6] = 32'hA5A5_A5A5;
    access(0, 32'h1005_0000, 0, TMO, 0, rd, er, lat, sa, ss);
    chk("edge_lat", lat, 6); chk("edge_err", er, 0); chk("edge_rdata", rd, 32'hA5A5_A5A5);
    access(0, 32'h1000_F000, 0, 0, 0, rd, er, lat, sa, ss);
    chk("csr_cnt_edge", rd, 2);

    access(0, 32'h1002_1004, 0, 2, 1, rd, er, lat, sa, ss);
    chk("ovl_sel", ss, 8'h02); chk("ovl_saddr", sa, 32'h1004);
    chk("ovl_lat", lat, 4); chk("ovl_rdata", rd, 32'hD000_0001); chk("ovl_err", er, 0);

    access(1, 32'h1000_0040, 32'hCAFE_0001, 1, 0, rd, er, lat, sa, ss);
    chk("wr0_lat", lat, 3); chk("wr0_rdata", rd, 0); chk("wr0_err", er, 0);

    access(1, 32'h1000_F004, 32'h5555_5555, 0, 0, rd, er, lat, sa, ss);
    chk("ro_wr_err", er, 0);
    access(0, 32'h1000_F004, 0, 0, 0, rd, er, lat, sa, ss);
    chk("csr_last2", rd, 32'h1003_0010);
    access(0, 32'h1000_F00C, 0, 0, 0, rd, er, lat, sa, ss);
    chk("csr_c", rd, 0);

    // Abort a stalled access with reset; select must drop without a clock edge
    @(posedge clk); #1;
    ack_k = -1;
    model_access(0, 32'h1006_0008, 0, -1);
    cpu_we = 0; cpu_addr = 32'h1006_0008; cpu_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort_sel_pre", slv_sel, 8'h80);
    #2 rst_n = 1'b0; cpu_req = 1'b0; m_active = 0;
    m_cnt = 0; m_last = 0; m_status = 0;
    #1 chk("abort_sel", slv_sel, 0);
    chk("abort_ready", cpu_ready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    access(0, 32'h1000_F000, 0, 0, 0, rd, er, lat, sa, ss);
    chk("post_cnt", rd, 0);
    access(0, 32'h1000_F004, 0, 0, 0, rd, er, lat, sa, ss);
    chk("post_last", rd, 0);
    access(0, 32'h1000_F008, 0, 0, 0, rd, er, lat, sa, ss);
    chk("post_stat", rd, 0);

    access(0, 32'h3000_0000, 0, 0, 0, rd, er, lat, sa, ss);
    access(1, 32'h0000_0100, 0, 0, 0, rd, er, lat, sa, ss);
    access(0, 32'h1000_F000, 0, 0, 0, rd, er, lat, sa, ss);
    chk("cnt_two", rd, 2);
    access(1, 32'h1000_F000, 32'hFFFF_FFFF, 0, 0, rd, er, lat, sa, ss);
    access(0, 32'h1000_F000, 0, 0, 0, rd, er, lat, sa, ss);
    chk("cnt_clear", rd, 0);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
